// File: rtl/valet_score_pkg.sv
// Shared types and tip constants for the valet scoring front end.
// Used by tip_event_encoder and retrieval_timer.
package valet_score_pkg;

  // Source order doubles as issue priority: a lower enum value is issued first.
  typedef enum logic [2:0] {
    SRC_THEFT,
    SRC_DROP,
    SRC_CAM,
    SRC_FIFO,
    SRC_RETR
  } tip_src_e;

  localparam int NUM_SRC = 5;

  typedef enum logic {
    RT_IDLE,
    RT_TIMING
  } retr_state_e;

  // Bucket code stored per queued retrieval score.
  typedef enum logic [1:0] {
    RB_FAST,
    RB_OK,
    RB_TIMEOUT
  } retr_code_e;

  localparam logic signed [7:0] TIP_CAM          = 8'sd100;
  localparam logic signed [7:0] TIP_FIFO         = 8'sd75;
  localparam logic signed [7:0] TIP_THEFT        = -8'sd100;
  localparam logic signed [7:0] TIP_DROP         = -8'sd50;
  localparam logic signed [7:0] TIP_RETR_FAST    = 8'sd50;
  localparam logic signed [7:0] TIP_RETR_OK      = 8'sd25;
  localparam logic signed [7:0] TIP_RETR_TIMEOUT = -8'sd25;

  // Compress a retrieval score into its 2-bit bucket code.
  function automatic retr_code_e retr_encode(input logic signed [7:0] score);
    if (score == TIP_RETR_FAST) begin
      return RB_FAST;
    end else if (score == TIP_RETR_OK) begin
      return RB_OK;
    end else begin
      return RB_TIMEOUT;
    end
  endfunction

  // Expand a stored bucket code back into its tip value.
  function automatic logic signed [7:0] retr_decode(input retr_code_e code);
    case (code)
      RB_FAST: return TIP_RETR_FAST;
      RB_OK:   return TIP_RETR_OK;
      default: return TIP_RETR_TIMEOUT;
    endcase
  endfunction

endpackage

// File: rtl/retrieval_timer.sv
// Retrieval latency timer: measures start-to-done latency and turns it
// into a bucketed tip score, or a penalty when the retrieval times out.
// score_valid/score are combinational for the current cycle.
module retrieval_timer
  import valet_score_pkg::*;
#(
  parameter int TMR_W        = 4,
  parameter int RETR_TIMEOUT = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              retr_start,
  input  logic              retr_done,
  output logic              score_valid,
  output logic signed [7:0] score
);

  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] FAST_MAX  = TMR_W'(2);
  localparam logic [TMR_W-1:0] OK_MAX    = TMR_W'(5);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(RETR_TIMEOUT);

  retr_state_e      state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  // State and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RT_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Next-state, latency bucketing and score generation.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    score_valid = 1'b0;
    score       = '0;
    case (state_q)
      RT_IDLE: begin
        if (retr_start) begin
          state_d = RT_TIMING;
          tmr_d   = TMR_ONE;
        end
      end
      RT_TIMING: begin
        tmr_d = tmr_q + TMR_ONE;
        if (retr_done) begin
          // Latencies from 6 up to the timeout earn nothing.
          if (tmr_q <= FAST_MAX) begin
            score_valid = 1'b1;
            score       = TIP_RETR_FAST;
          end else if (tmr_q <= OK_MAX) begin
            score_valid = 1'b1;
            score       = TIP_RETR_OK;
          end
          state_d = retr_start ? RT_TIMING : RT_IDLE;
          tmr_d   = TMR_ONE;
        end else if (tmr_q == TMR_LIMIT) begin
          // Timeout wins over a simultaneous restart; the restart still opens a new window.
          score_valid = 1'b1;
          score       = TIP_RETR_TIMEOUT;
          state_d     = retr_start ? RT_TIMING : RT_IDLE;
          tmr_d       = TMR_ONE;
        end else if (retr_start) begin
          // Abandon the open retrieval without scoring it.
          tmr_d = TMR_ONE;
        end
      end
      default: begin
        state_d = RT_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/tip_event_encoder.sv
// Tip event encoder: queues raw valet events per source and issues them
// one per cycle, by fixed priority, as a signed tip stream.
// Optional build macro TIP_LOSS_CNT_EN adds the lost_events counter port.
module tip_event_encoder
  import valet_score_pkg::*;
#(
  parameter int PEND_W       = 2,
  parameter int TMR_W        = 4,
  parameter int RETR_TIMEOUT = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cam_park,
  input  logic              fifo_park,
  input  logic              retr_start,
  input  logic              retr_done,
  input  logic              mercer_theft,
  input  logic              arrival_drop,
  output logic signed [7:0] tip_delta,
  output logic              tip_event_valid
`ifdef TIP_LOSS_CNT_EN
  ,
  output logic [7:0]        lost_events
`endif
);

  localparam int               RQ_DEPTH = 2**PEND_W - 1;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic              rt_score_valid;
  logic signed [7:0] rt_score;

  logic [PEND_W-1:0] cnt_q [NUM_SRC];
  logic [PEND_W-1:0] cnt_d [NUM_SRC];
  logic [1:0]        rq_q  [RQ_DEPTH];
  logic [1:0]        rq_d  [RQ_DEPTH];
  logic [NUM_SRC-1:0] inc, dec;
  logic              issue;
  tip_src_e          sel;
  logic signed [7:0] issue_val;
  logic [PEND_W-1:0] rq_wr_idx;
  logic signed [7:0] tip_delta_q, tip_delta_d;
  logic              tip_event_valid_q, tip_event_valid_d;

  retrieval_timer #(
    .TMR_W        (TMR_W),
    .RETR_TIMEOUT (RETR_TIMEOUT)
  ) u_retrieval_timer (
    .clk         (clk),
    .rst         (rst),
    .retr_start  (retr_start),
    .retr_done   (retr_done),
    .score_valid (rt_score_valid),
    .score       (rt_score)
  );

  // Priority pick of the next pending source and its tip value.
  always_comb begin
    inc       = {rt_score_valid, fifo_park, cam_park, arrival_drop, mercer_theft};
    dec       = '0;
    issue     = 1'b0;
    sel       = SRC_THEFT;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!issue && (cnt_q[i] != '0)) begin
        issue  = 1'b1;
        dec[i] = 1'b1;
        sel    = tip_src_e'(3'(i));
      end
    end
    case (sel)
      SRC_THEFT: issue_val = TIP_THEFT;
      SRC_DROP:  issue_val = TIP_DROP;
      SRC_CAM:   issue_val = TIP_CAM;
      SRC_FIFO:  issue_val = TIP_FIFO;
      SRC_RETR:  issue_val = retr_decode(retr_code_e'(rq_q[0]));
      default:   issue_val = '0;
    endcase
    tip_event_valid_d = issue;
    tip_delta_d       = issue ? issue_val : tip_delta_q;
  end

  // Pending counter update: net zero on simultaneous push/pop, drop on saturation.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc[i] && !dec[i]) begin
        if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else if (dec[i] && !inc[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
  end

  // Retrieval bucket queue: pop shifts toward slot 0, push lands after the survivors.
  always_comb begin
    rq_wr_idx = cnt_q[SRC_RETR] - PEND_W'(dec[SRC_RETR]);
    for (int j = 0; j < RQ_DEPTH; j++) begin
      rq_d[j] = rq_q[j];
    end
    if (dec[SRC_RETR]) begin
      for (int j = 0; j < RQ_DEPTH - 1; j++) begin
        rq_d[j] = rq_q[j+1];
      end
    end
    if (inc[SRC_RETR] && (dec[SRC_RETR] || (cnt_q[SRC_RETR] != CNT_MAX))) begin
      for (int j = 0; j < RQ_DEPTH; j++) begin
        if (PEND_W'(j) == rq_wr_idx) begin
          rq_d[j] = retr_encode(rt_score);
        end
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= '0;
      end
      tip_delta_q       <= '0;
      tip_event_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      tip_delta_q       <= tip_delta_d;
      tip_event_valid_q <= tip_event_valid_d;
    end
  end

  // Queue payload storage; occupancy is tracked by the RETR counter.
  always_ff @(posedge clk) begin
    for (int j = 0; j < RQ_DEPTH; j++) begin
      rq_q[j] <= rq_d[j];
    end
  end

  assign tip_delta       = tip_delta_q;
  assign tip_event_valid = tip_event_valid_q;

`ifdef TIP_LOSS_CNT_EN
  logic [7:0] lost_events_q, lost_events_d;
  logic [2:0] lost_n;
  logic [8:0] lost_sum;

  // Count every event discarded by a saturated counter, saturating at 255.
  always_comb begin
    lost_n = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (inc[i] && !dec[i] && (cnt_q[i] == CNT_MAX)) begin
        lost_n = lost_n + 3'd1;
      end
    end
    lost_sum      = {1'b0, lost_events_q} + {6'd0, lost_n};
    lost_events_d = lost_sum[8] ? 8'hFF : lost_sum[7:0];
  end

  // Lost-event counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lost_events_q <= '0;
    end else begin
      lost_events_q <= lost_events_d;
    end
  end

  assign lost_events = lost_events_q;
`endif

endmodule
